// File: rtl/manch_pkg.sv
// Shared types and constants for the Manchester encoder: FSM states,
// the sync code-violation pattern and counter widths.
package manch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_SYNC     = 2'd2,
    ST_DATA     = 2'd3
  } state_e;

  // Half-bit pattern 1,1,0,0 is illegal Manchester, so it marks the frame start.
  localparam logic [3:0] SYNC_CODE = 4'b1100;

  localparam int HB_CNT_W  = 4;
  localparam int PRE_CNT_W = 5;

  typedef logic [HB_CNT_W-1:0]  hb_cnt_t;
  typedef logic [PRE_CNT_W-1:0] pre_cnt_t;

  function automatic logic manch_half(input logic bit_val, input logic second_half);
    return bit_val ^ second_half;
  endfunction

endpackage

// File: rtl/manch_shift_reg.sv
// Byte holding register for the encoder: loads a byte, shifts it MSB first
// and presents the Manchester half-bit that will be on the line next cycle.
module manch_shift_reg
  import manch_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       shift_i,
  input  logic       second_half_i,
  output logic       half_bit_o
);

  logic [7:0] sr_q;
  logic [7:0] sr_d;

  // Next byte contents: load wins over shift.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = {sr_q[6:0], 1'b0};
    end else begin
      sr_d = sr_q;
    end
  end

  // Byte register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= 8'h00;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Looks at sr_d so the caller can register the half-bit with no extra latency.
  assign half_bit_o = manch_half(sr_d[7], second_half_i);

endmodule

// File: rtl/manchester_encoder.sv
// Framed Manchester transmitter: preamble, sync code violation, then bytes
// MSB first; consecutive bytes stream without gaps when offered in time.
module manchester_encoder
  import manch_pkg::*;
#(
  parameter int PREAMBLE_BITS = 4
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic [7:0] datain,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       dataout,
  output logic       busy,
  output logic       tx_done
);

  localparam pre_cnt_t PRE_LAST  = pre_cnt_t'(2 * PREAMBLE_BITS - 1);
  localparam hb_cnt_t  SYNC_LAST = hb_cnt_t'(3);
  localparam hb_cnt_t  DATA_LAST = hb_cnt_t'(15);

  state_e   state_q, state_d;
  pre_cnt_t pre_cnt_q, pre_cnt_d;
  hb_cnt_t  hb_cnt_q, hb_cnt_d;
  logic     dataout_q, dataout_d;
  logic     busy_q, busy_d;
  logic     tx_done_q, tx_done_d;
  logic     in_ready_q, in_ready_d;

  logic       xfer_s;
  logic       load_s;
  logic       shift_s;
  logic       half_bit_s;
  logic [1:0] sync_idx_s;

  assign xfer_s = in_valid & in_ready_q;

  // Next-state and counter logic.
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    hb_cnt_d  = hb_cnt_q;
    load_s    = 1'b0;
    shift_s   = 1'b0;
    tx_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer_s) begin
          state_d   = ST_PREAMBLE;
          pre_cnt_d = '0;
          load_s    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        if (pre_cnt_q == PRE_LAST) begin
          state_d   = ST_SYNC;
          pre_cnt_d = '0;
          hb_cnt_d  = '0;
        end else begin
          pre_cnt_d = pre_cnt_q + pre_cnt_t'(1);
        end
      end
      ST_SYNC: begin
        if (hb_cnt_q == SYNC_LAST) begin
          state_d  = ST_DATA;
          hb_cnt_d = '0;
        end else begin
          hb_cnt_d = hb_cnt_q + hb_cnt_t'(1);
        end
      end
      ST_DATA: begin
        hb_cnt_d = hb_cnt_q + hb_cnt_t'(1);
        if (hb_cnt_q == DATA_LAST) begin
          if (xfer_s) begin
            load_s = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            tx_done_d = 1'b1;
          end
        end else begin
          shift_s = hb_cnt_q[0];
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pre_cnt_d = '0;
        hb_cnt_d  = '0;
      end
    endcase
  end

  assign sync_idx_s = 2'd3 - hb_cnt_d[1:0];

  // Output values for the cycle about to start, so the registers carry no lag.
  always_comb begin
    dataout_d  = 1'b0;
    busy_d     = (state_d != ST_IDLE);
    in_ready_d = (state_d == ST_IDLE) ||
                 ((state_d == ST_DATA) && (hb_cnt_d == DATA_LAST));
    case (state_d)
      ST_IDLE:     dataout_d = 1'b0;
      ST_PREAMBLE: dataout_d = ~pre_cnt_d[0];
      ST_SYNC:     dataout_d = SYNC_CODE[sync_idx_s];
      ST_DATA:     dataout_d = half_bit_s;
      default:     dataout_d = 1'b0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pre_cnt_q  <= '0;
      hb_cnt_q   <= '0;
      dataout_q  <= 1'b0;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      hb_cnt_q   <= hb_cnt_d;
      dataout_q  <= dataout_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
      in_ready_q <= in_ready_d;
    end
  end

  manch_shift_reg u_shift_reg (
    .clk_i         (clkin),
    .rst_ni        (rst_n),
    .load_i        (load_s),
    .data_i        (datain),
    .shift_i       (shift_s),
    .second_half_i (hb_cnt_d[0]),
    .half_bit_o    (half_bit_s)
  );

  assign dataout  = dataout_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;
  assign in_ready = in_ready_q;

endmodule

// File: tb/tb_manchester_encoder.sv
// Directed bench for manchester_encoder: one instance with PREAMBLE_BITS=2
// and one with the default, sharing clock, reset and input stimulus.
module tb_manchester_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] datain;
  logic       rdy2, dout2, busy2, done2;
  logic       rdy4, dout4, busy4, done4;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  manchester_encoder #(.PREAMBLE_BITS(2)) u_dut2 (
    .clkin(clk), .rst_n(rst_n), .datain(datain), .in_valid(in_valid),
    .in_ready(rdy2), .dataout(dout2), .busy(busy2), .tx_done(done2)
  );

  manchester_encoder u_dut4 (
    .clkin(clk), .rst_n(rst_n), .datain(datain), .in_valid(in_valid),
    .in_ready(rdy4), .dataout(dout4), .busy(busy4), .tx_done(done4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    datain   = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Sends nbytes (1 or 2) from an idle DUT, holding in_valid high with junk
  // data while in_ready is low; records the line, ready, busy and done.
  task automatic run_frames(input bit sel4, input int nbytes,
                            input logic [7:0] b0, input logic [7:0] b1,
                            output logic [63:0] stream, output logic [63:0] rdy,
                            output int busy_n, output int done_in, output int done_after);
    int   len;
    int   k;
    logic r;
    len     = (sel4 ? 8 : 4) + 4 + 16 * nbytes;
    stream  = '0;
    rdy     = '0;
    busy_n  = 0;
    done_in = 0;
    k       = 1;
    datain   = b0;
    in_valid = 1'b1;
    tick();
    for (int i = 0; i < len; i++) begin
      r      = sel4 ? rdy4 : rdy2;
      stream = {stream[62:0], (sel4 ? dout4 : dout2)};
      rdy    = {rdy[62:0], r};
      busy_n  += int'(sel4 ? busy4 : busy2);
      done_in += int'(sel4 ? done4 : done2);
      if (r) begin
        if (k < nbytes) begin
          datain   = b1;
          in_valid = 1'b1;
          k++;
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        datain   = 8'(i * 37 + 11);
        in_valid = 1'b1;
      end
      tick();
    end
    done_after = int'(sel4 ? done4 : done2);
    in_valid   = 1'b0;
  endtask

  logic [63:0] st, rd;
  int          bn, dn, da;
  logic [7:0]  dec [2];
  logic        dec_fail;
  logic        f, g;
  int          s;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    datain   = 8'h00;
    #2;
    check_eq("rst_dataout",  64'(dout2), 64'h0);
    check_eq("rst_busy",     64'(busy2), 64'h0);
    check_eq("rst_tx_done",  64'(done2), 64'h0);
    check_eq("rst_in_ready", 64'(rdy2),  64'h0);
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_in_ready_held", 64'(rdy2), 64'h0);
    rst_n = 1'b1;
    tick();
    check_eq("in_ready_after_rst", 64'(rdy2), 64'h1);
    check_eq("idle_busy",          64'(busy2), 64'h0);

    // 0xA5 with a 2-bit preamble.
    run_frames(1'b0, 1, 8'hA5, 8'h00, st, rd, bn, dn, da);
    check_eq("a5_stream",    st, 64'hAC9966);
    check_eq("a5_in_ready",  rd, 64'h000001);
    check_eq("a5_busy_cyc",  64'(bn), 64'd24);
    check_eq("a5_done_in",   64'(dn), 64'd0);
    check_eq("a5_done_next", 64'(da), 64'd1);
    tick();
    check_eq("a5_done_width", 64'(done2), 64'h0);

    // 0x3C with in_valid held and datain churning mid-frame.
    run_frames(1'b0, 1, 8'h3C, 8'h00, st, rd, bn, dn, da);
    check_eq("hold_stream",   st, 64'hAC5AA5);
    check_eq("hold_in_ready", rd, 64'h000001);
    check_eq("hold_done",     64'(da), 64'd1);
    tick();

    // Reset during data half-bit 7 of 0xFF.
    datain   = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check_eq("abort_pre_busy", 64'(busy2), 64'h1);
    check_eq("abort_pre_dout", 64'(dout2), 64'h0);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy",     64'(busy2), 64'h0);
    check_eq("abort_dataout",  64'(dout2), 64'h0);
    check_eq("abort_in_ready", 64'(rdy2),  64'h0);
    check_eq("abort_tx_done",  64'(done2), 64'h0);
    @(negedge clk);
    @(negedge clk);
    check_eq("abort_no_done", 64'(done2), 64'h0);
    rst_n = 1'b1;
    tick();
    check_eq("abort_rel_done",  64'(done2), 64'h0);
    check_eq("abort_rel_ready", 64'(rdy2),  64'h1);
    run_frames(1'b0, 1, 8'hA5, 8'h00, st, rd, bn, dn, da);
    check_eq("post_abort_stream", st, 64'hAC9966);
    check_eq("post_abort_done",   64'(da), 64'd1);
    tick();

    // 0x3C, 0xC3 back-to-back, decoded by pairs after preamble and sync.
    run_frames(1'b0, 2, 8'h3C, 8'hC3, st, rd, bn, dn, da);
    check_eq("lb_stream",   st, 64'hAC5AA5A55A);
    check_eq("lb_in_ready", rd, 64'h0000010001);
    dec_fail = 1'b0;
    for (int j = 0; j < 2; j++) begin
      for (int b = 0; b < 8; b++) begin
        s = 8 + 16 * j + 2 * b;
        f = st[39 - s];
        g = st[38 - s];
        dec[j][7 - b] = f;
        if (f == g) dec_fail = 1'b1;
      end
    end
    check_eq("lb_byte0", 64'(dec[0]),   64'h3C);
    check_eq("lb_byte1", 64'(dec[1]),   64'hC3);
    check_eq("lb_fail",  64'(dec_fail), 64'h0);
    check_eq("lb_done_in", 64'(dn), 64'd0);
    check_eq("lb_done",    64'(da), 64'd1);

    // Default preamble: 0x00 then 0xFF with no gap.
    apply_reset();
    run_frames(1'b1, 2, 8'h00, 8'hFF, st, rd, bn, dn, da);
    check_eq("b2b_stream",   st, 64'hAAC5555AAAA);
    check_eq("b2b_in_ready", rd, 64'h00000010001);
    check_eq("b2b_busy_cyc", 64'(bn), 64'd44);
    check_eq("b2b_done_in",  64'(dn), 64'd0);
    check_eq("b2b_done",     64'(da), 64'd1);
    check_eq("b2b_idle_busy",  64'(busy4), 64'h0);
    check_eq("b2b_idle_ready", 64'(rdy4),  64'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
